// File: rtl/c2h_stream_arbiter_pkg.sv
// Shared definitions for the C2H stream arbiter: FSM state encoding and
// default stream widths.
package c2h_pkg;

    localparam int C2H_RX_LEN = 512;
    localparam int C2H_RX_BEN = C2H_RX_LEN / 8;

    // Encodings pinned so the state register stays a single legacy-compatible bit
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/c2h_stream_arbiter_if.sv
// Stream bundle between the traffic-generator ports and the merged C2H output.
// slave: arbiter view; master: requester/sink view.
interface c2h_stream_arbiter_if
    import c2h_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int RX_LEN    = C2H_RX_LEN,
    parameter int RX_BEN    = RX_LEN / 8
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        s_valid;
    logic [NUM_PORTS-1:0]        s_ready;
    logic [NUM_PORTS*RX_LEN-1:0] s_data;
    logic [NUM_PORTS*RX_BEN-1:0] s_ben;
    logic [NUM_PORTS-1:0]        s_last;

    logic                        m_valid;
    logic                        m_ready;
    logic [RX_LEN-1:0]           m_data;
    logic [RX_BEN-1:0]           m_ben;
    logic                        m_last;
    logic [PORT_W-1:0]           m_port;

    modport slave (
        input  s_valid, s_data, s_ben, s_last, m_ready,
        output s_ready, m_valid, m_data, m_ben, m_last, m_port
    );

    modport master (
        output s_valid, s_data, s_ben, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_ben, m_last, m_port
    );

endinterface

// File: rtl/c2h_stream_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request bit searched upward
// from (i_ptr + 1) modulo NUM_REQ.
module rr_priority_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    localparam int unsigned N_U = NUM_REQ;

    int unsigned w_dist;
    int unsigned w_best;

    // Pick the requester with the smallest rotated distance from the pointer
    always_comb begin
        w_dist = 0;
        w_best = N_U;
        o_idx  = '0;
        for (int unsigned p = 0; p < N_U; p++) begin
            w_dist = (p + N_U - 32'(i_ptr) - 1) % N_U;
            if (i_req[p] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_W'(p);
            end
        end
        o_any    = (w_best != N_U);
        o_onehot = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS requester streams onto one
// registered C2H output stream.
module c2h_stream_arbiter
    import c2h_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int RX_LEN    = C2H_RX_LEN,
    parameter int RX_BEN    = RX_LEN / 8
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic [NUM_PORTS-1:0] port_en,
    c2h_stream_arbiter_if.slave  strm,
    output logic                 busy,
    output logic [31:0]          pkt_total
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    arb_state_t           r_state;
    logic [PORT_W-1:0]    r_grant;
    logic [NUM_PORTS-1:0] r_grant_oh;
    logic [PORT_W-1:0]    r_rr_ptr;

    logic                 r_m_valid;
    logic                 r_m_last;
    logic [PORT_W-1:0]    r_m_port;
    logic [RX_LEN-1:0]    r_m_data;
    logic [RX_BEN-1:0]    r_m_ben;
    logic [31:0]          r_pkt_total;

    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_pick_oh;
    logic [PORT_W-1:0]    w_pick_idx;
    logic                 w_pick_any;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [RX_LEN-1:0]    w_sel_data;
    logic [RX_BEN-1:0]    w_sel_ben;
    logic                 w_out_free;
    logic                 w_accept;

    assign w_cand = strm.s_valid & port_en;

    rr_priority_pick #(
        .NUM_REQ (NUM_PORTS)
    ) u_pick (
        .i_req    (w_cand),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Select the granted port's beat from the flattened input buses
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_ben   = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == PORT_W'(p)) begin
                w_sel_valid = strm.s_valid[p];
                w_sel_last  = strm.s_last[p];
                w_sel_data  = strm.s_data[p*RX_LEN +: RX_LEN];
                w_sel_ben   = strm.s_ben[p*RX_BEN +: RX_BEN];
            end
        end
    end

    assign w_out_free   = strm.m_ready | ~r_m_valid;
    assign w_accept     = (r_state == XFER) & w_sel_valid & w_out_free;
    assign strm.s_ready = (r_state == XFER) ? (r_grant_oh & {NUM_PORTS{w_out_free}}) : '0;

    // Arbitration FSM: grant in ARB, hold grant until the last beat is taken
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state    <= ARB;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_rr_ptr   <= PORT_W'(NUM_PORTS - 1);
        end else begin
            case (r_state)
                ARB: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept && w_sel_last) begin
                        r_state  <= ARB;
                        r_rr_ptr <= r_grant;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Output register control: load on accept, drain on downstream handshake
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_port  <= '0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_sel_last;
            r_m_port  <= r_grant;
        end else if (strm.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Output payload register, qualified by m_valid so it carries no reset
    always_ff @(posedge axi_aclk) begin
        if (w_accept) begin
            r_m_data <= w_sel_data;
            r_m_ben  <= w_sel_ben;
        end
    end

    // Count packets completed downstream; wraps naturally at 32 bits
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_pkt_total <= '0;
        end else if (r_m_valid && strm.m_ready && r_m_last) begin
            r_pkt_total <= r_pkt_total + 32'd1;
        end
    end

    assign strm.m_valid = r_m_valid;
    assign strm.m_last  = r_m_last;
    assign strm.m_port  = r_m_port;
    assign strm.m_data  = r_m_data;
    assign strm.m_ben   = r_m_ben;
    assign busy         = (r_state == XFER) | r_m_valid;
    assign pkt_total    = r_pkt_total;

endmodule

// File: doc/c2h_stream_arbiter.md
C2H_STREAM_ARBITER -- requirements
Module: c2h_stream_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of traffic-generator requesters; 2..8.
REQ-002 Parameter RX_LEN, default 512: stream data width in bits.
REQ-003 Parameter RX_BEN, default RX_LEN/8: byte-enable width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 axi_areset  in  1  synchronous active-high reset.
REQ-007 port_en  in  NUM_PORTS  per-port arbitration enable, sampled only in ARB.
REQ-008 s_valid  in  NUM_PORTS  per-port beat valid.
REQ-009 s_ready  out  NUM_PORTS  per-port beat accept.
REQ-010 s_data  in  NUM_PORTS*RX_LEN  port p occupies bits [p*RX_LEN +: RX_LEN].
REQ-011 s_ben  in  NUM_PORTS*RX_BEN  port p occupies bits [p*RX_BEN +: RX_BEN].
REQ-012 s_last  in  NUM_PORTS  per-port end-of-packet.
REQ-013 m_valid/m_ready/m_data/m_ben/m_last  out/in/out/out/out  1/1/RX_LEN/RX_BEN/1  merged C2H stream toward QDMA.
REQ-014 m_port  out  clog2(NUM_PORTS)  source port of the current m_* beat.
REQ-015 busy  out  1  high while state is XFER or m_valid is high.
REQ-016 pkt_total  out  32  count of packets (m_last beats) accepted downstream.

Function
REQ-017 FSM states are ARB and XFER; reset state is ARB.
REQ-018 ARB: candidate set = s_valid & port_en; when non-empty, grant the first candidate searched from (rr_ptr+1) upward modulo NUM_PORTS, latch it in grant, and go to XFER next cycle.
REQ-019 ARB with an empty candidate set stays in ARB; all s_ready are low in ARB.
REQ-020 XFER: s_ready[grant] = m_ready | ~m_valid; every other s_ready is 0.
REQ-021 Accepted beat (s_valid[grant] & s_ready[grant]) loads the output register (data, ben, last, m_port=grant) and sets m_valid on the next edge; latency input to output is 1 cycle.
REQ-022 m_valid clears after a downstream handshake with no new beat loaded that cycle.
REQ-023 While m_valid & ~m_ready, m_data, m_ben, m_last and m_port hold stable.
REQ-024 Acceptance of a beat with s_last=1 returns FSM to ARB and sets rr_ptr to grant on the same edge.
REQ-025 Grant is packet-granular: no port switch before the granted port's last beat is accepted.
REQ-026 Deasserting port_en[grant] during XFER does not abort; the packet completes.
REQ-027 One ARB cycle separates consecutive packets, even from the same port.
REQ-028 A sole requester is regranted after one ARB cycle; no starvation: every continuously valid, enabled port is granted within NUM_PORTS packets.
REQ-029 pkt_total increments by 1 on each m_valid & m_ready & m_last and wraps from 0xFFFFFFFF to 0.
REQ-030 s_valid low mid-packet in XFER: state holds, no beat loaded, m_valid drains per REQ-022.

Reset
REQ-031 Reset: state=ARB, grant=0, rr_ptr=NUM_PORTS-1 (port 0 searched first), m_valid=0, m_last=0, m_port=0, s_ready=0, busy=0, pkt_total=0.
REQ-032 m_data/m_ben need no reset.
REQ-033 Reset mid-packet discards the partial packet; no beat is emitted the cycle after reset release.

Structure
REQ-034 Shared package c2h_pkg holds the state enum (ARB, XFER) and the default RX_LEN/RX_BEN constants.
REQ-035 One sub-module, rr_priority_pick: combinational round-robin first-set search (request vector, pointer -> one-hot/index, any).
REQ-036 Output register stage sits in the top module; no FIFO.

Verification
REQ-037 After reset, ports 0..3 all valid, 2-beat packets, m_ready=1 -> m_port order 0,1,2,3,0; pkt_total=5 after five packets.
REQ-038 Port 2 valid mid-packet of port 1 (3 beats) -> port 1 beats contiguous on m_*, port 2 first beat appears after one ARB cycle.
REQ-039 m_ready low 5 cycles mid-packet -> m_data/m_last/m_port held unchanged, s_ready[grant]=0 after 1 cycle, no beat lost or duplicated.
REQ-040 port_en=4'b0101, all valid -> only ports 0 and 2 granted, alternating; port_en[0] cleared mid-packet -> that packet finishes.
REQ-041 Reset asserted on beat 2 of a 4-beat packet -> next cycle m_valid=0, state ARB, pkt_total=0; restart grants port 0.
REQ-042 pkt_total preset by force to 0xFFFFFFFF, one packet -> pkt_total=0.
